// File: rtl/ldl_arb_pkg.sv
// ldl_arb_pkg
// Shared types and helper functions for the round-robin arbiter.
//   arb_state_t : arbiter FSM states (IDLE, GRANT)
//   lsb_isolate : keeps only the lowest set bit of a vector
//   above_mask  : mask with every bit strictly above a pointer set
// The helpers work on the widest supported request vector (MAX_N bits).
// Callers zero-extend their operands and truncate the result back down.
package ldl_arb_pkg;

  localparam int MAX_BIN = 8;
  localparam int MAX_N   = 1 << MAX_BIN;

  typedef enum logic {
    IDLE,
    GRANT
  } arb_state_t;

  // Two's-complement trick: x & -x leaves only the lowest set bit.
  function automatic logic [MAX_N-1:0] lsb_isolate(input logic [MAX_N-1:0] x);
    return x & (~x + MAX_N'(1));
  endfunction

  // Bits (ptr+1) and upward are set; ptr itself and everything below are clear.
  function automatic logic [MAX_N-1:0] above_mask(input logic [MAX_BIN-1:0] ptr);
    logic [MAX_N-1:0] ones;
    ones = '1;
    return (ones << ptr) << 1;
  endfunction

endpackage

// File: rtl/ldl_hot2bin_pri.sv
// ldl_hot2bin_pri
// Converts a one-hot vector to its binary index. If several bits happen to be
// set, the lowest index wins.
//   x     : one-hot input, 1<<BIN_WIDTH bits
//   y     : binary index of the winning bit, 0 when x is all zero
//   valid : high when any bit of x is set
module ldl_hot2bin_pri #(
  parameter int BIN_WIDTH = 3
) (
  input  logic [(1<<BIN_WIDTH)-1:0] x,
  output logic [BIN_WIDTH-1:0]      y,
  output logic                      valid
);

  localparam int N = 1 << BIN_WIDTH;

  // Scan from the top down so that the lowest set bit is the last one written.
  always_comb begin
    y = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (x[i]) begin
        y = i[BIN_WIDTH-1:0];
      end
    end
  end

  assign valid = |x;

endmodule

// File: rtl/ldl_rr_arbiter.sv
// ldl_rr_arbiter
// Round-robin arbiter for 1<<BIN_WIDTH requesters. A grant is held until the
// grantee pulses done. The optional watchdog (MAX_HOLD > 0) forces a release
// after MAX_HOLD cycles. On a release the next winner is loaded in the same
// cycle, so back-to-back grants have no idle bubble.
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset
//   req       : request vector, bit i is requester i
//   done      : release pulse from the current grantee
//   gnt       : registered one-hot grant, zero when idle
//   gnt_id    : binary index of gnt
//   gnt_valid : high while a grant is held
//   timeout   : one-cycle pulse after a watchdog release
module ldl_rr_arbiter
  import ldl_arb_pkg::*;
#(
  parameter int BIN_WIDTH = 3,
  parameter int MAX_HOLD  = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [(1<<BIN_WIDTH)-1:0] req,
  input  logic                      done,
  output logic [(1<<BIN_WIDTH)-1:0] gnt,
  output logic [BIN_WIDTH-1:0]      gnt_id,
  output logic                      gnt_valid,
  output logic                      timeout
);

  localparam int N      = 1 << BIN_WIDTH;
  localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HOLD_W'(MAX_HOLD - 1) : '0;

  arb_state_t         state_q, state_d;
  logic [N-1:0]       gnt_q, gnt_d;
  logic [BIN_WIDTH-1:0] ptr_q, ptr_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               timeout_q, timeout_d;

  logic [MAX_N-1:0]   req_ext;
  logic [MAX_BIN-1:0] ptr_ext;
  logic [MAX_N-1:0]   masked_ext;
  logic [N-1:0]       winner;
  logic [BIN_WIDTH-1:0] winner_id;
  logic               watchdog;
  logic               release_now;

  // Round-robin pick: requesters above the last grantee are preferred. When
  // none of them ask, the lowest requester overall wins, which is how the
  // pointer wraps from N-1 back to 0. The winner is isolated to a single bit
  // before anything encodes it.
  always_comb begin
    req_ext = '0;
    req_ext[N-1:0] = req;
    ptr_ext = '0;
    ptr_ext[BIN_WIDTH-1:0] = ptr_q;
    masked_ext = req_ext & above_mask(ptr_ext);
    winner = N'(lsb_isolate((masked_ext != '0) ? masked_ext : req_ext));
    winner_id = '0;
    for (int i = 0; i < N; i++) begin
      if (winner[i]) begin
        winner_id = i[BIN_WIDTH-1:0];
      end
    end
  end

  // The watchdog fires only when done is absent, so a done that lands on the
  // limit cycle counts as an ordinary release.
  assign watchdog    = (MAX_HOLD > 0) && (hold_q == HOLD_LAST) && !done;
  assign release_now = done || watchdog;

  // Next-state logic. A release re-runs arbitration immediately. The same
  // requester may win again if it is the only one still asking.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = GRANT;
          gnt_d   = winner;
          ptr_d   = winner_id;
          hold_d  = '0;
        end
      end
      GRANT: begin
        if (release_now) begin
          timeout_d = watchdog;
          hold_d    = '0;
          if (|req) begin
            gnt_d = winner;
            ptr_d = winner_id;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end else if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // Reset parks the pointer on N-1 so that the first grant favours index 0.
  // A reset during a grant drops it silently, with no timeout pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      ptr_q     <= BIN_WIDTH'(N - 1);
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  ldl_hot2bin_pri #(.BIN_WIDTH(BIN_WIDTH)) u_enc (
    .x     (gnt_q),
    .y     (gnt_id),
    .valid (gnt_valid)
  );

  assign gnt     = gnt_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_ldl_rr_arbiter.sv
// tb_ldl_rr_arbiter
// Drives two arbiters, one without the watchdog and one with MAX_HOLD=4.
// Stimulus pushes the expected post-edge outputs into a queue. A separate
// monitor pops them on the falling edge and compares them against the DUT.
module tb_ldl_rr_arbiter;

  typedef struct {
    int         cyc;
    int         dut;
    logic [7:0] gnt;
    logic [2:0] id;
    logic       valid;
    logic       to;
    string      name;
  } expect_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstA = 1'b1, doneA = 1'b0;
  logic [7:0] reqA = 8'h00;
  logic [7:0] gntA;
  logic [2:0] idA;
  logic       validA, toA;

  logic       rstB = 1'b1, doneB = 1'b0;
  logic [7:0] reqB = 8'h00;
  logic [7:0] gntB;
  logic [2:0] idB;
  logic       validB, toB;

  int edgeCount = 0;
  int checkCount = 0;
  int passCount = 0;
  expect_t sb[$];

  ldl_rr_arbiter #(.BIN_WIDTH(3), .MAX_HOLD(0)) dutA (
    .clk(clk), .rst(rstA), .req(reqA), .done(doneA),
    .gnt(gntA), .gnt_id(idA), .gnt_valid(validA), .timeout(toA)
  );

  ldl_rr_arbiter #(.BIN_WIDTH(3), .MAX_HOLD(4)) dutB (
    .clk(clk), .rst(rstB), .req(reqB), .done(doneB),
    .gnt(gntB), .gnt_id(idB), .gnt_valid(validB), .timeout(toB)
  );

  always @(posedge clk) edgeCount <= edgeCount + 1;

  // Index of a one-hot grant as the bench expects it.
  function automatic logic [2:0] expId(input logic [7:0] g);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (g[i]) r = 3'(i);
    end
    return r;
  endfunction

  // Drive one DUT for the next edge and queue what it must show afterwards.
  task automatic applyStimulus(input int d, input logic [7:0] r, input logic dn,
                               input logic rs, input logic [7:0] eg,
                               input logic et, input string nm);
    expect_t e;
    if (d == 0) begin
      reqA = r; doneA = dn; rstA = rs;
    end else begin
      reqB = r; doneB = dn; rstB = rs;
    end
    e.cyc = edgeCount + 1;
    e.dut = d;
    e.gnt = eg;
    e.id = expId(eg);
    e.valid = |eg;
    e.to = et;
    e.name = nm;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input expect_t e);
    logic [7:0] g;
    logic [2:0] id;
    logic       v, t;
    if (e.dut == 0) begin
      g = gntA; id = idA; v = validA; t = toA;
    end else begin
      g = gntB; id = idB; v = validB; t = toB;
    end
    checkCount++;
    if (g === e.gnt && id === e.id && v === e.valid && t === e.to) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s cyc=%0d dut=%0d: got gnt=%h id=%0d valid=%b timeout=%b, expected gnt=%h id=%0d valid=%b timeout=%b",
               e.name, e.cyc, e.dut, g, id, v, t, e.gnt, e.id, e.valid, e.to);
    end
  endtask

  // Monitor: compare every queued expectation once its edge has passed.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= edgeCount) begin
      checkOutput(sb.pop_front());
    end
  end

  initial begin
    logic [7:0] g;
    int waitCycles;

    // Reset and idle behaviour, including done while idle.
    applyStimulus(1, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, "resetB");
    for (int i = 0; i < 3; i++) applyStimulus(0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, "resetA");
    for (int i = 0; i < 2; i++) applyStimulus(0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, "idleDone");

    // Full rotation with done every cycle, wrapping from 7 back to 0.
    applyStimulus(0, 8'hFF, 1'b0, 1'b0, 8'h01, 1'b0, "firstGrant");
    for (int k = 1; k <= 9; k++) begin
      g = 8'h01 << (k % 8);
      applyStimulus(0, 8'hFF, 1'b1, 1'b0, g, 1'b0, "rotate");
    end
    applyStimulus(0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, "releaseIdle");

    // Two requesters, done on every third grant cycle.
    applyStimulus(0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, "reset81");
    applyStimulus(0, 8'h81, 1'b0, 1'b0, 8'h01, 1'b0, "alt01a");
    applyStimulus(0, 8'h81, 1'b0, 1'b0, 8'h01, 1'b0, "alt01b");
    applyStimulus(0, 8'h81, 1'b0, 1'b0, 8'h01, 1'b0, "alt01c");
    applyStimulus(0, 8'h81, 1'b1, 1'b0, 8'h80, 1'b0, "alt80a");
    applyStimulus(0, 8'h81, 1'b0, 1'b0, 8'h80, 1'b0, "alt80b");
    applyStimulus(0, 8'h81, 1'b0, 1'b0, 8'h80, 1'b0, "alt80c");
    applyStimulus(0, 8'h81, 1'b1, 1'b0, 8'h01, 1'b0, "altWrap");
    applyStimulus(0, 8'h80, 1'b0, 1'b0, 8'h01, 1'b0, "dropReqHold");
    applyStimulus(0, 8'h80, 1'b1, 1'b0, 8'h80, 1'b0, "afterDrop");
    applyStimulus(0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, "altIdle");

    // Reset in the middle of a grant at index 3.
    applyStimulus(0, 8'hFF, 1'b0, 1'b0, 8'h01, 1'b0, "preRst0");
    applyStimulus(0, 8'hFF, 1'b1, 1'b0, 8'h02, 1'b0, "preRst1");
    applyStimulus(0, 8'hFF, 1'b1, 1'b0, 8'h04, 1'b0, "preRst2");
    applyStimulus(0, 8'hFF, 1'b1, 1'b0, 8'h08, 1'b0, "preRst3");
    applyStimulus(0, 8'hFF, 1'b0, 1'b1, 8'h00, 1'b0, "midRst");
    applyStimulus(0, 8'hFF, 1'b0, 1'b0, 8'h01, 1'b0, "postRst");
    applyStimulus(0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, "postRstIdle");

    // Watchdog with a single requester: re-granted with a timeout every 4 cycles.
    applyStimulus(1, 8'h04, 1'b0, 1'b0, 8'h04, 1'b0, "wdFirst");
    for (int n = 2; n <= 14; n++) begin
      applyStimulus(1, 8'h04, 1'b0, 1'b0, 8'h04, (n == 5 || n == 9 || n == 13), "wdHold");
    end
    applyStimulus(1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, "wdIdle");

    // done on the limit cycle wins over the watchdog; then a genuine forced switch.
    applyStimulus(1, 8'h30, 1'b0, 1'b0, 8'h10, 1'b0, "lim4a");
    applyStimulus(1, 8'h30, 1'b0, 1'b0, 8'h10, 1'b0, "lim4b");
    applyStimulus(1, 8'h30, 1'b0, 1'b0, 8'h10, 1'b0, "lim4c");
    applyStimulus(1, 8'h30, 1'b0, 1'b0, 8'h10, 1'b0, "lim4d");
    applyStimulus(1, 8'h30, 1'b1, 1'b0, 8'h20, 1'b0, "doneOnLimit");
    applyStimulus(1, 8'h30, 1'b0, 1'b0, 8'h20, 1'b0, "lim5b");
    applyStimulus(1, 8'h30, 1'b0, 1'b0, 8'h20, 1'b0, "lim5c");
    applyStimulus(1, 8'h30, 1'b0, 1'b0, 8'h20, 1'b0, "lim5d");
    applyStimulus(1, 8'h30, 1'b0, 1'b0, 8'h10, 1'b1, "forcedSwitch");
    applyStimulus(1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, "finalIdle");

    // Let the monitor drain the queue, within a bounded number of cycles.
    waitCycles = 0;
    while (sb.size() > 0 && waitCycles < 20) begin
      @(posedge clk);
      waitCycles++;
    end
    if (sb.size() > 0) begin
      checkCount++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
